// File: rtl/ble_cmd_rx.sv
// 8N1 UART receiver for the BLE command link with rdy/clr_rdy handshake and framing-error pulse.
// Optional build macro RX_CMD_FILTER_EN: only 'G' (0x47) and 'S' (0x53) are delivered.
module ble_cmd_rx #(
    parameter int unsigned BAUD_DIV = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err
);

    localparam int unsigned HALF_DIV = BAUD_DIV / 2;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned BIT_W    = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } state_t;

    state_t             state, state_nxt;
    logic               rx_s1, rx_s2, rx_s3;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [BIT_W-1:0]   bit_cnt, bit_nxt;
    logic [7:0]         shreg, shreg_nxt;
    logic [7:0]         data_nxt;
    logic               rdy_nxt;
    logic               frm_nxt;
    logic               fall_c;
    logic               accept_c;
    logic               cnt_zero_c;

    assign fall_c     = rx_s3 & ~rx_s2;
    assign cnt_zero_c = (cnt == CNT_W'(0));

`ifdef RX_CMD_FILTER_EN
    assign accept_c = (shreg == 8'h47) || (shreg == 8'h53);
`else
    assign accept_c = 1'b1;
`endif

    // Synchroniser, edge-detect flop and all registered state
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_s3   <= 1'b1;
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            rx_data <= '0;
            rdy     <= 1'b0;
            frm_err <= 1'b0;
        end else begin
            rx_s1   <= RX;
            rx_s2   <= rx_s1;
            rx_s3   <= rx_s2;
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_cnt <= bit_nxt;
            shreg   <= shreg_nxt;
            rx_data <= data_nxt;
            rdy     <= rdy_nxt;
            frm_err <= frm_nxt;
        end
    end

    // Next-state and output logic; a stop-bit set overrides clr_rdy
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bit_nxt   = bit_cnt;
        shreg_nxt = shreg;
        data_nxt  = rx_data;
        rdy_nxt   = clr_rdy ? 1'b0 : rdy;
        frm_nxt   = 1'b0;

        unique case (state)
            IDLE: begin
                if (fall_c) begin
                    state_nxt = START;
                    cnt_nxt   = CNT_W'(HALF_DIV - 1);
                end
            end
            START: begin
                if (!cnt_zero_c) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else if (rx_s2) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = DATA;
                    cnt_nxt   = CNT_W'(BAUD_DIV - 1);
                    bit_nxt   = '0;
                    rdy_nxt   = 1'b0;
                end
            end
            DATA: begin
                if (!cnt_zero_c) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    shreg_nxt = {rx_s2, shreg[7:1]};
                    cnt_nxt   = CNT_W'(BAUD_DIV - 1);
                    bit_nxt   = bit_cnt + BIT_W'(1);
                    if (bit_cnt == BIT_W'(7)) begin
                        state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (!cnt_zero_c) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else if (rx_s2) begin
                    state_nxt = IDLE;
                    if (accept_c) begin
                        data_nxt = shreg;
                        rdy_nxt  = 1'b1;
                    end
                end else begin
                    state_nxt = BRK;
                    frm_nxt   = 1'b1;
                end
            end
            BRK: begin
                if (rx_s2) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ble_cmd_rx.sv
// Directed self-checking bench for ble_cmd_rx, run with a short baud divider.
module tb_ble_cmd_rx;

    localparam int unsigned B       = 32;
    localparam int          EXP_LAT = 9 * B + B / 2 + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       RX = 1'b1;
    logic       clr_rdy = 1'b0;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frm_err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rise_cyc = -1;
    int fall_cnt = 0;
    int frm_cnt = 0;
    int frm_long = 0;
    logic rdy_q = 1'b0;
    logic frm_q = 1'b0;

    ble_cmd_rx #(.BAUD_DIV(B)) dut (
        .clk     (clk),
        .rst     (rst),
        .RX      (RX),
        .clr_rdy (clr_rdy),
        .rx_data (rx_data),
        .rdy     (rdy),
        .frm_err (frm_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor: first rdy rise per frame, rdy falls, frm_err pulses and their width
    always @(negedge clk) begin
        if (rdy === 1'b1 && rdy_q === 1'b0 && rise_cyc < 0) rise_cyc = cyc;
        if (rdy_q === 1'b1 && rdy === 1'b0) fall_cnt++;
        if (frm_err === 1'b1) begin
            frm_cnt++;
            if (frm_q === 1'b1) frm_long++;
        end
        rdy_q = rdy;
        frm_q = frm_err;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(posedge clk);
        #1 RX = 1'b0;
        start_cyc = cyc;
        rise_cyc  = -1;
        repeat (B) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 RX = b[i];
            repeat (B) @(posedge clk);
        end
        #1 RX = stop;
        repeat (B) @(posedge clk);
    endtask

    task automatic pulse_clr();
        @(posedge clk);
        #1 clr_rdy = 1'b1;
        @(posedge clk);
        #1 clr_rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        RX  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        if (rdy !== 1'b0) begin n_bad++; $display("FAIL reset_rdy: got %b want 0", rdy); end
        n_cmp++;
        if (rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", rx_data); end
        n_cmp++;
        if (frm_err !== 1'b0) begin n_bad++; $display("FAIL reset_frm: got %b want 0", frm_err); end
        n_cmp++;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_basic();
        int lat;
        send_frame(8'h47, 1'b1);
        @(negedge clk);
        lat = rise_cyc - start_cyc;
        if (lat < EXP_LAT - 2 || lat > EXP_LAT + 2) begin
            n_bad++; $display("FAIL basic_latency: got %0d want %0d+-2", lat, EXP_LAT);
        end
        n_cmp++;
        if (rx_data !== 8'h47) begin n_bad++; $display("FAIL basic_data: got %h want 47", rx_data); end
        n_cmp++;
        if (frm_cnt !== 0) begin n_bad++; $display("FAIL basic_frm: got %0d pulses want 0", frm_cnt); end
        n_cmp++;
        pulse_clr();
        @(negedge clk);
        if (rdy !== 1'b0) begin n_bad++; $display("FAIL basic_clr_rdy: got %b want 0", rdy); end
        n_cmp++;
        if (rx_data !== 8'h47) begin n_bad++; $display("FAIL basic_clr_data: got %h want 47", rx_data); end
        n_cmp++;
    endtask

    task automatic test_glitch();
        @(posedge clk);
        #1 RX = 1'b0;
        repeat (6) @(posedge clk);
        #1 RX = 1'b1;
        repeat (2 * B) @(posedge clk);
        @(negedge clk);
        if (rdy !== 1'b0) begin n_bad++; $display("FAIL glitch_rdy: got %b want 0", rdy); end
        n_cmp++;
        if (frm_cnt !== 0) begin n_bad++; $display("FAIL glitch_frm: got %0d pulses want 0", frm_cnt); end
        n_cmp++;
        send_frame(8'h53, 1'b1);
        @(negedge clk);
        if (rdy !== 1'b1) begin n_bad++; $display("FAIL glitch_next_rdy: got %b want 1", rdy); end
        n_cmp++;
        if (rx_data !== 8'h53) begin n_bad++; $display("FAIL glitch_next_data: got %h want 53", rx_data); end
        n_cmp++;
    endtask

    task automatic test_framing();
        int f0;
        int lat;
        send_frame(8'h47, 1'b1);
        pulse_clr();
        f0 = frm_cnt;
        send_frame(8'h53, 1'b0);
        repeat (3 * B) @(posedge clk);
        @(negedge clk);
        if (frm_cnt - f0 !== 1) begin n_bad++; $display("FAIL frm_count: got %0d pulses want 1", frm_cnt - f0); end
        n_cmp++;
        if (frm_long !== 0) begin n_bad++; $display("FAIL frm_width: got %0d long pulses want 0", frm_long); end
        n_cmp++;
        if (rdy !== 1'b0) begin n_bad++; $display("FAIL frm_rdy: got %b want 0", rdy); end
        n_cmp++;
        if (rx_data !== 8'h47) begin n_bad++; $display("FAIL frm_data: got %h want 47", rx_data); end
        n_cmp++;
        @(posedge clk);
        #1 RX = 1'b1;
        repeat (B) @(posedge clk);
        send_frame(8'h47, 1'b1);
        @(negedge clk);
        lat = rise_cyc - start_cyc;
        if (lat < EXP_LAT - 2 || lat > EXP_LAT + 2) begin
            n_bad++; $display("FAIL frm_next_latency: got %0d want %0d+-2", lat, EXP_LAT);
        end
        n_cmp++;
        if (rx_data !== 8'h47) begin n_bad++; $display("FAIL frm_next_data: got %h want 47", rx_data); end
        n_cmp++;
        if (frm_cnt - f0 !== 1) begin n_bad++; $display("FAIL frm_after: got %0d pulses want 1", frm_cnt - f0); end
        n_cmp++;
    endtask

    task automatic test_back_to_back();
        int fc0;
        fc0 = fall_cnt;
        send_frame(8'h53, 1'b1);
        @(negedge clk);
        if (fall_cnt - fc0 !== 1) begin n_bad++; $display("FAIL b2b_rdy_drop: got %0d falls want 1", fall_cnt - fc0); end
        n_cmp++;
        if (rdy !== 1'b1) begin n_bad++; $display("FAIL b2b_rdy: got %b want 1", rdy); end
        n_cmp++;
        if (rx_data !== 8'h53) begin n_bad++; $display("FAIL b2b_data: got %h want 53", rx_data); end
        n_cmp++;
        // clr_rdy lands on the stop-sample edge; the set must win
        fork
            send_frame(8'h47, 1'b1);
            begin
                @(posedge clk);
                repeat (EXP_LAT - 1) @(posedge clk);
                #1 clr_rdy = 1'b1;
                @(posedge clk);
                #1 clr_rdy = 1'b0;
            end
        join
        @(negedge clk);
        if (rdy !== 1'b1) begin n_bad++; $display("FAIL b2b_set_wins: got %b want 1", rdy); end
        n_cmp++;
        if (rx_data !== 8'h47) begin n_bad++; $display("FAIL b2b_set_data: got %h want 47", rx_data); end
        n_cmp++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        b = 8'h47;
        @(posedge clk);
        #1 RX = 1'b0;
        repeat (B) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            #1 RX = b[i];
            repeat ((i == 4) ? B / 2 : B) @(posedge clk);
        end
        #1 rst = 1'b1;
        RX = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        if (rdy !== 1'b0) begin n_bad++; $display("FAIL rstmid_rdy: got %b want 0", rdy); end
        n_cmp++;
        if (rx_data !== 8'h00) begin n_bad++; $display("FAIL rstmid_data: got %h want 00", rx_data); end
        n_cmp++;
        if (frm_err !== 1'b0) begin n_bad++; $display("FAIL rstmid_frm: got %b want 0", frm_err); end
        n_cmp++;
        repeat (2 * B) @(posedge clk);
        send_frame(8'h53, 1'b1);
        @(negedge clk);
        if (rdy !== 1'b1) begin n_bad++; $display("FAIL rstmid_next_rdy: got %b want 1", rdy); end
        n_cmp++;
        if (rx_data !== 8'h53) begin n_bad++; $display("FAIL rstmid_next_data: got %h want 53", rx_data); end
        n_cmp++;
    endtask

    task automatic test_filter();
        send_frame(8'h41, 1'b1);
        @(negedge clk);
`ifdef RX_CMD_FILTER_EN
        if (rdy !== 1'b0) begin n_bad++; $display("FAIL filt_drop_rdy: got %b want 0", rdy); end
        n_cmp++;
        if (rx_data !== 8'h53) begin n_bad++; $display("FAIL filt_drop_data: got %h want 53", rx_data); end
        n_cmp++;
        send_frame(8'h47, 1'b1);
        @(negedge clk);
        if (rdy !== 1'b1) begin n_bad++; $display("FAIL filt_pass_rdy: got %b want 1", rdy); end
        n_cmp++;
        if (rx_data !== 8'h47) begin n_bad++; $display("FAIL filt_pass_data: got %h want 47", rx_data); end
        n_cmp++;
`else
        if (rdy !== 1'b1) begin n_bad++; $display("FAIL nofilt_rdy: got %b want 1", rdy); end
        n_cmp++;
        if (rx_data !== 8'h41) begin n_bad++; $display("FAIL nofilt_data: got %h want 41", rx_data); end
        n_cmp++;
`endif
        if (frm_cnt !== 1) begin n_bad++; $display("FAIL filt_frm: got %0d pulses want 1", frm_cnt); end
        n_cmp++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_reset_mid();
        test_filter();
        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
